// File: rtl/ofdm_subcarrier_scheduler.sv
// ofdm_subcarrier_scheduler
//
// Purpose:
//   Builds one 64-bin OFDM symbol for the IFFT from the QPSK mapper stream.
//   Bins are emitted in ascending order 0..63. Data bins take the next mapper
//   symbol. Pilot bins carry +/-PILOT_AMP on I. Null bins (DC and guards) carry
//   zero. The mapper is only pulled (s_axis_tready) while a data bin is loading.
//
// Ports:
//   clk              clock
//   rst              asynchronous reset, active low
//   s_axis_tvalid    mapper symbol valid
//   s_axis_tdata     mapper symbol {Q, I}
//   s_axis_tlast     last mapper symbol of the packet
//   s_axis_tready    scheduler takes a mapper symbol this cycle
//   s_bit_symb_last  mapper marks the 48th data symbol of an OFDM symbol
//   m_axis_tvalid    IFFT bin valid
//   m_axis_tdata     IFFT bin {Q, I}
//   m_axis_tlast     bin 63 of the final OFDM symbol of a packet
//   m_axis_tuser     bin 63 of every OFDM symbol
//   m_bin_idx        bin index of the word on m_axis_tdata
//   m_axis_tready    IFFT accepts the current bin
//   sym_err          one-cycle pulse on a data-count / symb_last mismatch
module ofdm_subcarrier_scheduler #(
  parameter int unsigned     DW        = 16,
  parameter logic [DW-1:0]   PILOT_AMP = 16'h5A82
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axis_tvalid,
  input  logic [2*DW-1:0]   s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              s_bit_symb_last,
  output logic              m_axis_tvalid,
  output logic [2*DW-1:0]   m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic [5:0]        m_bin_idx,
  input  logic              m_axis_tready,
  output logic              sym_err
);

  localparam logic [DW-1:0] PILOT_NEG = -PILOT_AMP;
  localparam logic [6:0]    LFSR_SEED = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [5:0]      bin_reg, bin_next;
  logic            pkt_flag_reg, pkt_flag_next;
  logic [6:0]      lfsr_reg, lfsr_next;
  logic            m_valid_reg, m_valid_next;
  logic [2*DW-1:0] m_data_reg, m_data_next;
  logic            m_last_reg, m_last_next;
  logic            m_user_reg, m_user_next;
  logic [5:0]      m_idx_reg, m_idx_next;
  logic            sym_err_reg, sym_err_next;

  // Constant per-bin class maps.
  logic [63:0] null_map;
  logic [63:0] pilot_map;
  logic [63:0] pilot_base_neg_map;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bin_map
      assign null_map[gi]           = (gi == 0) || ((gi >= 27) && (gi <= 37));
      assign pilot_map[gi]          = (gi == 7) || (gi == 21) || (gi == 43) || (gi == 57);
      assign pilot_base_neg_map[gi] = (gi == 21);
    end
  endgenerate

  logic            bin_null;
  logic            bin_pilot;
  logic            bin_data;
  logic            bin_last;
  logic            lfsr_fb;
  logic            pilot_neg;
  logic [2*DW-1:0] pilot_word;
  logic            ld;
  logic            accept;
  logic            load;
  logic            pkt_end;

  assign bin_null   = null_map[bin_reg];
  assign bin_pilot  = pilot_map[bin_reg];
  assign bin_data   = !bin_null && !bin_pilot;
  assign bin_last   = (bin_reg == 6'd63);

  // x^7 + x^4 + 1: the feedback bit is also the polarity bit of the current
  // OFDM symbol (0 -> +1, 1 -> -1). Seed all-ones gives 0 for symbol one.
  assign lfsr_fb    = lfsr_reg[6] ^ lfsr_reg[3];
  assign pilot_neg  = pilot_base_neg_map[bin_reg] ^ lfsr_fb;
  assign pilot_word = {{DW{1'b0}}, (pilot_neg ? PILOT_NEG : PILOT_AMP)};

  // Output register can take a new word when empty or being drained.
  assign ld = (!m_valid_reg || m_axis_tready) && (state_reg == RUN);

  // Once the packet flag is set mid-symbol, the rest of the data bins are
  // zero-filled, so the mapper is not pulled any more.
  assign s_axis_tready = ld && bin_data && !pkt_flag_reg;
  assign accept        = s_axis_tready && s_axis_tvalid;
  assign load          = ld && (!bin_data || pkt_flag_reg || s_axis_tvalid);

  // Packet ends with this symbol if tlast was already seen, or arrives now.
  assign pkt_end = pkt_flag_reg || (accept && s_axis_tlast);

  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    pkt_flag_next = pkt_flag_reg;
    lfsr_next     = lfsr_reg;
    m_valid_next  = m_valid_reg && !m_axis_tready;
    m_data_next   = m_data_reg;
    m_last_next   = m_last_reg;
    m_user_next   = m_user_reg;
    m_idx_next    = m_idx_reg;
    // symb_last must be high exactly on the data beat in bin 63; a tlast on
    // any earlier data beat truncates the symbol and is also an error.
    sym_err_next  = accept && ((s_bit_symb_last != bin_last) ||
                               (s_axis_tlast && !bin_last));

    unique case (state_reg)
      IDLE: begin
        if (s_axis_tvalid) begin
          state_next = RUN;
          bin_next   = 6'd0;
        end
      end

      RUN: begin
        if (load) begin
          m_valid_next = 1'b1;
          m_idx_next   = bin_reg;
          m_user_next  = bin_last;
          m_last_next  = bin_last && pkt_end;
          if (bin_null) begin
            m_data_next = '0;
          end else if (bin_pilot) begin
            m_data_next = pilot_word;
          end else if (pkt_flag_reg) begin
            m_data_next = '0;
          end else begin
            m_data_next = s_axis_tdata;
          end

          bin_next = bin_reg + 6'd1;
          if (accept && s_axis_tlast) begin
            pkt_flag_next = 1'b1;
          end

          if (bin_last) begin
            if (pkt_end) begin
              pkt_flag_next = 1'b0;
              lfsr_next     = LFSR_SEED;
              state_next    = IDLE;
            end else begin
              lfsr_next = {lfsr_reg[5:0], lfsr_fb};
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bin_reg      <= 6'd0;
      pkt_flag_reg <= 1'b0;
      lfsr_reg     <= LFSR_SEED;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      m_last_reg   <= 1'b0;
      m_user_reg   <= 1'b0;
      m_idx_reg    <= 6'd0;
      sym_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      pkt_flag_reg <= pkt_flag_next;
      lfsr_reg     <= lfsr_next;
      m_valid_reg  <= m_valid_next;
      m_data_reg   <= m_data_next;
      m_last_reg   <= m_last_next;
      m_user_reg   <= m_user_next;
      m_idx_reg    <= m_idx_next;
      sym_err_reg  <= sym_err_next;
    end
  end

  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tlast  = m_last_reg;
  assign m_axis_tuser  = m_user_reg;
  assign m_bin_idx     = m_idx_reg;
  assign sym_err       = sym_err_reg;

endmodule

// File: tb/tb_ofdm_subcarrier_scheduler.sv
// tb_ofdm_subcarrier_scheduler
//
// Table of packet scenarios (inputs plus hand-derived expectations: pilot
// polarity per OFDM symbol, sym_err pulses and the offending data beat).
// Each scenario streams its packet, collects every IFFT beat and compares it
// with the expected bin map. A reset-state check and a mid-symbol reset are
// the hand-written sequences.
module tb_ofdm_subcarrier_scheduler;

  logic        clk;
  logic        rst;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        s_bit_symb_last;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [5:0]  m_bin_idx;
  logic        m_axis_tready;
  logic        sym_err;

  ofdm_subcarrier_scheduler #(
    .DW(16),
    .PILOT_AMP(16'h5A82)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .s_bit_symb_last(s_bit_symb_last),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .m_bin_idx(m_bin_idx),
    .m_axis_tready(m_axis_tready),
    .sym_err(sym_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         n_sym;      // OFDM symbols the packet occupies
    int         n_data;     // data beats supplied, tlast on the last one
    int         sl_extra;   // beat with a spurious symb_last (0 = none)
    bit         sl_drop;    // omit symb_last on every 48th beat
    bit         const_data; // all beats 32'h5A825A82
    bit         rnd_ready;  // ~50% m_axis_tready
    bit         rnd_valid;  // random s_axis_tvalid gaps
    int         abort_bin;  // assert reset when this bin is on the output (-1 = none)
    logic [7:0] pol;        // expected pilot negation per OFDM symbol (bit s)
    int         exp_err;    // expected sym_err pulses
    int         err_beat;   // accepted beat whose accept causes the pulse (0 = none)
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // 0 = null, 1 = pilot, 2 = data
  function automatic int bin_class(input int b);
    if (b == 0 || (b >= 27 && b <= 37)) return 0;
    if (b == 7 || b == 21 || b == 43 || b == 57) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] beat_word(input int sc, input int i, input bit c);
    logic [31:0] w;
    if (c) w = 32'h5A825A82;
    else   w = 32'hD0000000 | (32'(sc) << 20) | 32'(i);
    return w;
  endfunction

  task automatic run_vec(input int sc, input vec_t v);
    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];
    logic [39:0] cur;
    logic [39:0] held;
    bit          held_v = 0;
    bit          aborted = 0;
    int          d = 0;
    int          nacc = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    int          first_err_cyc = -1;
    int          acc_cyc = -1;
    int          hold_bad = 0;
    int          n_exp;

    // expected beats {tlast, tuser, idx, data}
    for (int s = 0; s < v.n_sym; s++) begin
      for (int b = 0; b < 64; b++) begin
        logic [31:0] w;
        int cls;
        cls = bin_class(b);
        if (cls == 0) begin
          w = 32'h0;
        end else if (cls == 1) begin
          w = (((b == 21) ? 1'b1 : 1'b0) ^ v.pol[s]) ? 32'h0000A57E : 32'h00005A82;
        end else if (d < v.n_data) begin
          d++;
          w = beat_word(sc, d, v.const_data);
        end else begin
          w = 32'h0;
        end
        exp_q.push_back({(b == 63 && s == v.n_sym - 1), (b == 63), 6'(b), w});
      end
    end
    n_exp = exp_q.size();

    while (got_q.size() < n_exp && cyc < 6000) begin
      @(negedge clk);
      cur = {m_axis_tlast, m_axis_tuser, m_bin_idx, m_axis_tdata};
      if (held_v && (!m_axis_tvalid || cur !== held)) hold_bad++;
      if (sym_err) begin
        err_cnt++;
        if (first_err_cyc < 0) first_err_cyc = cyc;
      end
      if (v.abort_bin >= 0 && m_axis_tvalid && m_bin_idx == 6'(v.abort_bin)) begin
        rst = 1'b0;
        #1;
        chk($sformatf("v%0d_rst_m_tvalid", sc), 64'(m_axis_tvalid), 64'd0);
        chk($sformatf("v%0d_rst_m_tdata", sc), 64'(m_axis_tdata), 64'd0);
        chk($sformatf("v%0d_rst_m_tlast", sc), 64'(m_axis_tlast), 64'd0);
        chk($sformatf("v%0d_rst_m_tuser", sc), 64'(m_axis_tuser), 64'd0);
        chk($sformatf("v%0d_rst_bin_idx", sc), 64'(m_bin_idx), 64'd0);
        chk($sformatf("v%0d_rst_sym_err", sc), 64'(sym_err), 64'd0);
        chk($sformatf("v%0d_rst_s_tready", sc), 64'(s_axis_tready), 64'd0);
        s_axis_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        aborted = 1;
        break;
      end
      if (nacc < v.n_data) begin
        s_axis_tvalid   = !v.rnd_valid || ($urandom_range(0, 1) == 1);
        s_axis_tdata    = beat_word(sc, nacc + 1, v.const_data);
        s_axis_tlast    = (nacc + 1 == v.n_data);
        s_bit_symb_last = (((nacc + 1) % 48 == 0) && !v.sl_drop) || (nacc + 1 == v.sl_extra);
      end else begin
        // Offer a bogus beat while zero-filled bins are still pending: it must not be taken.
        s_axis_tvalid   = (got_q.size() < n_exp - 4);
        s_axis_tdata    = 32'hDEADBEEF;
        s_axis_tlast    = 1'b0;
        s_bit_symb_last = 1'b0;
      end
      m_axis_tready = !v.rnd_ready || ($urandom_range(0, 1) == 1);
      #1;
      held_v = m_axis_tvalid && !m_axis_tready;
      held   = cur;
      if (m_axis_tvalid && m_axis_tready) got_q.push_back(cur);
      if (s_axis_tvalid && s_axis_tready) begin
        nacc++;
        if (nacc == v.err_beat) acc_cyc = cyc;
      end
      cyc++;
    end

    for (int i = 0; i < got_q.size() && i < n_exp; i++) begin
      chk($sformatf("v%0d_bin%0d", sc, i % 64), 64'(got_q[i]), 64'(exp_q[i]));
    end

    if (!aborted) begin
      s_axis_tvalid   = 1'b0;
      s_bit_symb_last = 1'b0;
      s_axis_tlast    = 1'b0;
      m_axis_tready   = 1'b1;
      repeat (4) begin
        @(negedge clk);
        #1;
        if (sym_err) err_cnt++;
      end
      chk($sformatf("v%0d_beat_count", sc), 64'(got_q.size()), 64'(n_exp));
      chk($sformatf("v%0d_accepted", sc), 64'(nacc), 64'(v.n_data));
      chk($sformatf("v%0d_sym_err_count", sc), 64'(err_cnt), 64'(v.exp_err));
      if (v.err_beat > 0) begin
        chk($sformatf("v%0d_sym_err_delay", sc), 64'(first_err_cyc - acc_cyc), 64'd1);
      end
      chk($sformatf("v%0d_hold_stable", sc), 64'(hold_bad), 64'd0);
      chk($sformatf("v%0d_idle_m_tvalid", sc), 64'(m_axis_tvalid), 64'd0);
      chk($sformatf("v%0d_idle_s_tready", sc), 64'(s_axis_tready), 64'd0);
    end
    $display("vec %0d: beats=%0d accepted=%0d sym_err=%0d aborted=%0d",
             sc, got_q.size(), nacc, err_cnt, aborted);
  endtask

  initial begin
    //           n_sym n_data sl_x drop  const  rrdy   rval   abort pol    err beat
    vecs[0] = '{1,    48,    0,   1'b0, 1'b1,  1'b0,  1'b0,  -1,   8'h00, 0,  0};
    vecs[1] = '{5,    240,   0,   1'b0, 1'b0,  1'b0,  1'b0,  -1,   8'h10, 0,  0};
    vecs[2] = '{2,    96,    0,   1'b0, 1'b0,  1'b1,  1'b1,  -1,   8'h00, 0,  0};
    vecs[3] = '{1,    30,    0,   1'b0, 1'b0,  1'b0,  1'b0,  -1,   8'h00, 1,  30};
    vecs[4] = '{1,    48,    20,  1'b0, 1'b0,  1'b0,  1'b0,  -1,   8'h00, 1,  20};
    vecs[5] = '{1,    48,    0,   1'b1, 1'b0,  1'b1,  1'b0,  -1,   8'h00, 1,  48};
    vecs[6] = '{1,    48,    0,   1'b0, 1'b0,  1'b0,  1'b1,  40,   8'h00, 0,  0};
    vecs[7] = '{1,    48,    0,   1'b0, 1'b0,  1'b0,  1'b0,  -1,   8'h00, 0,  0};
    vecs[8] = '{1,    48,    0,   1'b0, 1'b0,  1'b1,  1'b1,  -1,   8'h00, 0,  0};

    rst             = 1'b0;
    s_axis_tvalid   = 1'b0;
    s_axis_tdata    = 32'h0;
    s_axis_tlast    = 1'b0;
    s_bit_symb_last = 1'b0;
    m_axis_tready   = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset_m_tdata", 64'(m_axis_tdata), 64'd0);
    chk("reset_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("reset_m_tuser", 64'(m_axis_tuser), 64'd0);
    chk("reset_bin_idx", 64'(m_bin_idx), 64'd0);
    chk("reset_sym_err", 64'(sym_err), 64'd0);
    chk("reset_s_tready", 64'(s_axis_tready), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // Idle with no input: nothing may be emitted.
    chk("idle_no_output", 64'(m_axis_tvalid), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
